mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Shares one registered N-to-1 multiplexer datapath among N requesters with a req/gnt handshake and a bounded-hold fairness rule. The arbitration scheme is chosen at elaboration time: round-robin or fixed priority. It sits in front of the shared select mux and drives its select, so no requester toggles `sel` directly.

## Interface
- `N`, 4: number of requesters, 2..16.
- `W`, 8: data width per requester.
- `USE_RR`, 1: 1 selects round-robin; 0 selects fixed priority, where index 0 is highest.
- `MAX_HOLD`, 4: maximum consecutive granted cycles while another request is pending. 0 means unlimited.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous assert and active-low.
- `req`  in  N  request per requester, level-sensitive.
- `din`  in  N*W  requester data, with slice i = `din[i*W +: W]`.
- `gnt`  out  N  one-hot grant, or all zero.
- `sel`  out  $clog2(N)  index of the current owner. Valid when `gnt` is nonzero.
- `dout`  out  W  registered mux output.
- `dout_vld`  out  1  marks `dout` as valid.

## Operation
- State machine `IDLE` → `OWN`:
  - `IDLE`: if any `req` bit is set, the picker chooses a winner. `gnt`/`sel` are registered next cycle and the FSM moves to `OWN`.
  - `OWN`, owner still requesting and hold not expired: keep `gnt`/`sel` and increment `hold_cnt`.
  - `OWN`, owner drops `req`: re-arbitrate in the same cycle over the remaining requests.
    - With a winner, the new grant appears the next cycle with no idle gap.
    - With no winner, `gnt` goes to 0 next cycle and the FSM returns to `IDLE`.
  - `OWN`, `hold_cnt` == `MAX_HOLD`-1 and another requester pending: forced re-arbitration with the current owner masked, then regrant and clear `hold_cnt`.
    - With no other request pending, the owner keeps the grant and `hold_cnt` saturates.
- Round-robin pointer `ptr`:
  - After granting index i, `ptr` = (i+1) mod N, wrapping from N-1 to 0.
  - The search starts at `ptr` and proceeds upward with wrap.
- Fixed priority: the lowest set index wins, excluding the masked owner on forced release.
- Datapath register (only the owner's data can pass):
  - Each cycle, `dout` <= `din[sel]` and `dout_vld` <= 1 when `gnt[sel]` && `req[sel]`.
  - Otherwise `dout_vld` <= 0 and `dout` holds its value.
- Requests from non-owners are ignored for data.
- `gnt` is never multi-hot. It also never asserts for a requester whose `req` was low in the arbitration cycle.

## Timing
- Reset values: `gnt`=0, `sel`=0, `dout`=0, `dout_vld`=0, `ptr`=0, `hold_cnt`=0, state `IDLE`.
- Reset mid-grant drops `gnt` immediately and asynchronously. After `rstn` deasserts, arbitration restarts from `ptr`=0.
- Latency:
  - `req` rising in cycle t gives `gnt` in t+1.
  - The first `dout_vld` is at t+2, carrying `din` sampled at t+1.
- Owner drops `req` at cycle t: `gnt` changes at t+1. `dout_vld` is already 0 at t+1, because the t sample has `req` low.
- Simultaneous owner release and new requests: the new winner is granted at t+1 (back-to-back).
- Forced-release handover: the owner holds for exactly `MAX_HOLD` grant cycles.

## Structure
- Package `mux_arb_pkg`:
  - state enum `arb_state_e` {IDLE, OWN}
  - function `clog2_min1` (returns 1 when N=1 to keep widths legal)
- Sub-module `arb_pick`: purely combinational.
  - Inputs: `req`, `mask`, `ptr`. Outputs: `win_vld`, `win_idx`.
  - Uses a generate-if on `USE_RR` to select the rotate-and-priority-encode or the plain priority-encode implementation.
- The top level holds the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
- Reset with `req`=4'b1111 held: all outputs 0 during reset. First cycle after release gives `gnt`=4'b0001, `sel`=0; next cycle `dout`=`din[0]` and `dout_vld`=1.
- `USE_RR`=1, `MAX_HOLD`=4, all four requesting continuously: each owner holds 4 cycles. Grant order is 0,1,2,3,0 with no gap cycles, and `ptr` wraps from 3 to 0.
- `USE_RR`=0, `req`=4'b1010 continuous: grants alternate 1 (4 cycles), 3 (4 cycles), 1. Index 1 regains the grant right after forced release.
- Single requester 2 holding 20 cycles: `gnt`=4'b0100 for all 20 cycles (no forced release), then `gnt`=0 the cycle after `req[2]` drops and the FSM returns to `IDLE`.
- Owner 0 drops `req` in the same cycle `req[3]` rises: `gnt`=4'b1000 next cycle, and `dout_vld` is low exactly one cycle between the two streams.
- `rstn` pulsed low mid-grant to index 2, asynchronous to `clk`: `gnt`/`dout_vld` drop to 0 before the next edge, and re-arbitration after release starts from index 0.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// mux_arb_pkg: shared types and helpers for the mux_arbiter slice.
//   arb_state_e  - arbiter FSM state encoding
//   clog2_min1   - ceil(log2(n)) clamped to at least 1 so index vectors stay legal
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arbiter_pick.sv
// arb_pick: combinational winner selection for mux_arbiter.
//   req     in   N   raw requests
//   mask    in   N   requesters excluded from this pick (current owner)
//   ptr     in   SW  round-robin start index (unused for fixed priority)
//   win_vld out  1   some unmasked request exists
//   win_idx out  SW  chosen requester index
module arb_pick
  import mux_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int USE_RR = 1,
  parameter int SW     = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [SW-1:0] ptr,
  output logic          win_vld,
  output logic [SW-1:0] win_idx
);

  logic [N-1:0] elig;

  assign elig    = req & ~mask;
  assign win_vld = |elig;

  generate
    if (USE_RR != 0) begin : g_rr
      // Lowest eligible index at or above ptr wins; if none, the search has
      // wrapped, so the lowest eligible index overall wins.
      always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (elig[i]) win_idx = SW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
          if (elig[i] && (SW'(i) >= ptr)) win_idx = SW'(i);
        end
      end
    end else begin : g_fixed
      logic unused_ptr;
      assign unused_ptr = ^ptr;

      always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (elig[i]) win_idx = SW'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: req/gnt arbiter driving a shared registered N-to-1 data mux,
// with a bounded-hold rule that forces handover after MAX_HOLD grant cycles
// when someone else is waiting.
//   clk, rstn   clock, async active-low reset
//   req   in  N    level requests
//   din   in  N*W  requester data, slice i = din[i*W +: W]
//   gnt   out N    one-hot grant (or zero)
//   sel   out SW   current owner index, valid while gnt != 0
//   dout  out W    registered owner data
//   dout_vld out 1 dout carries a fresh owner sample
//
// state | meaning
// IDLE  | no grant outstanding, pick a winner from any request
// OWN   | gnt/sel held by one owner, hold_cnt counts its grant cycles
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int USE_RR   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N-1:0]                req,
  input  logic [N*W-1:0]              din,
  output logic [N-1:0]                gnt,
  output logic [clog2_min1(N)-1:0]    sel,
  output logic [W-1:0]                dout,
  output logic                        dout_vld
);

  localparam int SW = clog2_min1(N);
  localparam int HW = clog2_min1(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [SW-1:0] LAST_IDX  = SW'(N - 1);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            dout_vld_q, dout_vld_d;

  logic            win_vld;
  logic [SW-1:0]   win_idx;
  logic            owner_req, others_pending, expired, take_win;
  logic [W-1:0]    din_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_din
    assign din_arr[i] = din[i*W +: W];
  end

  // Masking with the current grant excludes the owner on forced release;
  // in IDLE the grant is zero, and when the owner has dropped req the mask
  // changes nothing.
  arb_pick #(
    .N      (N),
    .USE_RR (USE_RR),
    .SW     (SW)
  ) u_pick (
    .req     (req),
    .mask    (gnt_q),
    .ptr     (ptr_q),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    sel_d          = sel_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    take_win       = 1'b0;
    owner_req      = req[sel_q];
    others_pending = |(req & ~gnt_q);
    expired        = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    case (state_q)
      IDLE: take_win = win_vld;
      OWN: begin
        if (!owner_req) begin
          if (win_vld) begin
            take_win = 1'b1;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (expired && others_pending) begin
          take_win = 1'b1;
        end else if ((MAX_HOLD != 0) && !expired) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (take_win) begin
      gnt_d      = N'(1) << win_idx;
      sel_d      = win_idx;
      ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      hold_cnt_d = '0;
      state_d    = OWN;
    end
  end

  // Only the registered owner's data passes, and only while it still requests.
  always_comb begin
    dout_vld_d = gnt_q[sel_q] & req[sel_q];
    dout_d     = dout_vld_d ? din_arr[sel_q] : dout_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;
  import mux_arb_pkg::*;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   sel;
    logic         vld;
    logic [W-1:0] dout;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt_rr, gnt_fp;
  logic [1:0]     sel_rr, sel_fp;
  logic [W-1:0]   dout_rr, dout_fp;
  logic           vld_rr, vld_fp;

  logic           use_fp;
  logic [N-1:0]   obs_gnt;
  logic [1:0]     obs_sel;
  logic [W-1:0]   obs_dout;
  logic           obs_vld;

  exp_t           sb[$];
  logic [N-1:0]   prev_gnt;
  int             n_checks = 0;
  int             n_pass   = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.N(N), .W(W), .USE_RR(1), .MAX_HOLD(MAX_HOLD)) u_rr (
    .clk(clk), .rstn(rstn), .req(req), .din(din),
    .gnt(gnt_rr), .sel(sel_rr), .dout(dout_rr), .dout_vld(vld_rr)
  );

  mux_arbiter #(.N(N), .W(W), .USE_RR(0), .MAX_HOLD(MAX_HOLD)) u_fp (
    .clk(clk), .rstn(rstn), .req(req), .din(din),
    .gnt(gnt_fp), .sel(sel_fp), .dout(dout_fp), .dout_vld(vld_fp)
  );

  assign obs_gnt  = use_fp ? gnt_fp  : gnt_rr;
  assign obs_sel  = use_fp ? sel_fp  : sel_rr;
  assign obs_dout = use_fp ? dout_fp : dout_rr;
  assign obs_vld  = use_fp ? vld_fp  : vld_rr;

  // Drive one cycle of stimulus and queue what must be visible after the edge:
  // grant g, and data from whoever was expected to own the previous cycle.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] g);
    exp_t e;
    req = r;
    for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
    e.gnt  = g;
    e.sel  = '0;
    e.dout = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) e.sel = 2'(i);
      if (prev_gnt[i]) e.dout = din[i*W +: W];
    end
    e.vld = |(prev_gnt & r);
    sb.push_back(e);
    prev_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    req      = '0;
    din      = '0;
    prev_gnt = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    use_fp = 1'b0;
    rstn   = 1'b0;
    req    = 4'b1111;
    din    = 32'hA1B2C3D4;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({gnt_rr, sel_rr, dout_rr, vld_rr} !== '0)
      $display("FAIL reset_rr: got gnt=%b sel=%0d dout=%h vld=%b want all 0", gnt_rr, sel_rr, dout_rr, vld_rr);
    else n_pass++;
    n_checks++;
    if ({gnt_fp, sel_fp, dout_fp, vld_fp} !== '0)
      $display("FAIL reset_fp: got gnt=%b sel=%0d dout=%h vld=%b want all 0", gnt_fp, sel_fp, dout_fp, vld_fp);
    else n_pass++;
    @(negedge clk);
    rstn     = 1'b1;
    prev_gnt = '0;
    sb.delete();
    for (int c = 1; c <= 2; c++) begin
      step(4'b1111, 4'b0001);
      e = sb.pop_front();
      n_checks++;
      if (obs_gnt !== e.gnt) $display("FAIL reset_gnt c%0d: got %b want %b", c, obs_gnt, e.gnt);
      else n_pass++;
      n_checks++;
      if (obs_sel !== e.sel) $display("FAIL reset_sel c%0d: got %0d want %0d", c, obs_sel, e.sel);
      else n_pass++;
      n_checks++;
      if (obs_vld !== e.vld) $display("FAIL reset_vld c%0d: got %b want %b", c, obs_vld, e.vld);
      else n_pass++;
      if (e.vld) begin
        n_checks++;
        if (obs_dout !== e.dout) $display("FAIL reset_dout c%0d: got %h want %h", c, obs_dout, e.dout);
        else n_pass++;
      end
    end
    n_checks++;
    if (gnt_fp !== 4'b0001) $display("FAIL reset_fp_gnt: got %b want 0001", gnt_fp);
    else n_pass++;
  endtask

  task automatic test_rr_rotation();
    exp_t e;
    use_fp = 1'b0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step(4'b1111, 4'(1) << (((c - 1) / MAX_HOLD) % N));
      e = sb.pop_front();
      n_checks++;
      if (obs_gnt !== e.gnt) $display("FAIL rr_gnt c%0d: got %b want %b", c, obs_gnt, e.gnt);
      else n_pass++;
      n_checks++;
      if (obs_sel !== e.sel) $display("FAIL rr_sel c%0d: got %0d want %0d", c, obs_sel, e.sel);
      else n_pass++;
      n_checks++;
      if (obs_vld !== e.vld) $display("FAIL rr_vld c%0d: got %b want %b", c, obs_vld, e.vld);
      else n_pass++;
      if (e.vld) begin
        n_checks++;
        if (obs_dout !== e.dout) $display("FAIL rr_dout c%0d: got %h want %h", c, obs_dout, e.dout);
        else n_pass++;
      end
    end
  endtask

  task automatic test_fixed_hold();
    exp_t e;
    int   own;
    use_fp = 1'b1;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      own = ((((c - 1) / MAX_HOLD) % 2) == 0) ? 1 : 3;
      step(4'b1010, 4'(1) << own);
      e = sb.pop_front();
      n_checks++;
      if (obs_gnt !== e.gnt) $display("FAIL fp_gnt c%0d: got %b want %b", c, obs_gnt, e.gnt);
      else n_pass++;
      n_checks++;
      if (obs_vld !== e.vld) $display("FAIL fp_vld c%0d: got %b want %b", c, obs_vld, e.vld);
      else n_pass++;
      if (e.vld) begin
        n_checks++;
        if (obs_dout !== e.dout) $display("FAIL fp_dout c%0d: got %h want %h", c, obs_dout, e.dout);
        else n_pass++;
      end
    end
    use_fp = 1'b0;
  endtask

  task automatic test_single_hold();
    exp_t e;
    use_fp = 1'b0;
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      if (c <= 20) step(4'b0100, 4'b0100);
      else         step(4'b0000, 4'b0000);
      e = sb.pop_front();
      n_checks++;
      if (obs_gnt !== e.gnt) $display("FAIL single_gnt c%0d: got %b want %b", c, obs_gnt, e.gnt);
      else n_pass++;
      n_checks++;
      if (obs_vld !== e.vld) $display("FAIL single_vld c%0d: got %b want %b", c, obs_vld, e.vld);
      else n_pass++;
      if (e.vld) begin
        n_checks++;
        if (obs_dout !== e.dout) $display("FAIL single_dout c%0d: got %h want %h", c, obs_dout, e.dout);
        else n_pass++;
      end
    end
    n_checks++;
    if (u_rr.state_q !== IDLE) $display("FAIL single_state: got %0d want IDLE", u_rr.state_q);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    use_fp = 1'b0;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      if (c <= 3) step(4'b0001, 4'b0001);
      else        step(4'b1000, 4'b1000);
      e = sb.pop_front();
      n_checks++;
      if (obs_gnt !== e.gnt) $display("FAIL b2b_gnt c%0d: got %b want %b", c, obs_gnt, e.gnt);
      else n_pass++;
      n_checks++;
      if (obs_vld !== e.vld) $display("FAIL b2b_vld c%0d: got %b want %b", c, obs_vld, e.vld);
      else n_pass++;
      if (e.vld) begin
        n_checks++;
        if (obs_dout !== e.dout) $display("FAIL b2b_dout c%0d: got %h want %h", c, obs_dout, e.dout);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    use_fp = 1'b0;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      step(4'b0100, 4'b0100);
      e = sb.pop_front();
      n_checks++;
      if (obs_gnt !== e.gnt) $display("FAIL areset_pre_gnt c%0d: got %b want %b", c, obs_gnt, e.gnt);
      else n_pass++;
    end
    #3;
    rstn = 1'b0;
    req  = 4'b1111;
    #1;
    n_checks++;
    if (gnt_rr !== 4'b0000) $display("FAIL areset_gnt: got %b want 0000", gnt_rr);
    else n_pass++;
    n_checks++;
    if (vld_rr !== 1'b0) $display("FAIL areset_vld: got %b want 0", vld_rr);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rstn     = 1'b1;
    prev_gnt = '0;
    sb.delete();
    step(4'b1111, 4'b0001);
    e = sb.pop_front();
    n_checks++;
    if (obs_gnt !== e.gnt) $display("FAIL areset_restart_gnt: got %b want %b", obs_gnt, e.gnt);
    else n_pass++;
  endtask

  initial begin
    rstn   = 1'b0;
    req    = '0;
    din    = '0;
    use_fp = 1'b0;
    prev_gnt = '0;
    test_reset();
    test_rr_rotation();
    test_fixed_hold();
    test_single_hold();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
